// File: rtl/blinkseq_if.sv
// Button and display bundle for the LED sequencer.
// The board side is the master. The sequencer is the slave.
interface blinkseq_if #(
    parameter int NLED = 4,
    parameter int SPDW = 2
);
    logic [2:0]      BTN;
    logic [NLED-1:0] LED;
    logic [SPDW-1:0] SPEED;
    logic [1:0]      MODE;
    logic            PAUSED;

    modport master (output BTN, input LED, SPEED, MODE, PAUSED);
    modport slave  (input BTN, output LED, SPEED, MODE, PAUSED);
endinterface

// File: rtl/blinkseq.sv
// LED pattern sequencer with four display modes, a selectable step rate and pause.
// Each raw button is synchronised and debounced into a single-cycle press event.
module debounce #(
    parameter int DEBW = 16
) (
    input  logic CLK,
    input  logic RST,
    input  logic BTNIN,
    output logic BTNOUT
);
    logic            r_sync0;
    logic            r_sync1;
    logic            r_state;
    logic            r_pulse;
    logic [DEBW-1:0] r_cnt;
    logic            w_settled;

    // A new level is accepted after it has stayed stable for 2**DEBW cycles.
    assign w_settled = (r_sync1 != r_state) && (r_cnt == {DEBW{1'b1}});
    assign BTNOUT    = r_pulse;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sync0 <= 1'b0;
            r_sync1 <= 1'b0;
            r_state <= 1'b0;
            r_pulse <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync0 <= BTNIN;
            r_sync1 <= r_sync0;
            r_pulse <= w_settled && r_sync1;
            if (r_sync1 == r_state) begin
                r_cnt <= '0;
            end else if (w_settled) begin
                r_state <= r_sync1;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end
endmodule

module blinkseq #(
    parameter int NLED = 4,
    parameter int DIVW = 27,
    parameter int SPDW = 2,
    parameter int DEBW = 16
) (
    input  logic       CLK,
    input  logic       RST,
    blinkseq_if.slave  bus
);
    typedef enum logic [1:0] {
        M_ROTATE   = 2'd0,
        M_PINGPONG = 2'd1,
        M_BINARY   = 2'd2,
        M_BLINK    = 2'd3
    } mode_t;

    localparam logic [NLED-1:0] LED_ONE = {{(NLED-1){1'b0}}, 1'b1};

    logic [2:0]      w_ev;
    logic [DIVW-1:0] r_cnt,    w_cntNext;
    logic [DIVW-1:0] w_mask;
    logic [NLED-1:0] r_led,    w_ledNext;
    logic [SPDW-1:0] r_speed,  w_speedNext;
    mode_t           r_mode,   w_modeNext;
    logic            r_dirUp,  w_dirUpNext;
    logic            r_paused, w_pausedNext;
    logic            w_tick;
    logic            w_step;

    for (genvar g = 0; g < 3; g++) begin : g_deb
        debounce #(.DEBW(DEBW)) u_deb (
            .CLK    (CLK),
            .RST    (RST),
            .BTNIN  (bus.BTN[g]),
            .BTNOUT (w_ev[g])
        );
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt    <= '0;
            r_led    <= LED_ONE;
            r_speed  <= '0;
            r_mode   <= M_ROTATE;
            r_dirUp  <= 1'b1;
            r_paused <= 1'b0;
        end else begin
            r_cnt    <= w_cntNext;
            r_led    <= w_ledNext;
            r_speed  <= w_speedNext;
            r_mode   <= w_modeNext;
            r_dirUp  <= w_dirUpNext;
            r_paused <= w_pausedNext;
        end
    end

    // A mode event reinitialises the pattern and takes priority over a step in the same cycle.
    always_comb begin
        w_mask       = {DIVW{1'b1}} >> r_speed;
        w_tick       = (r_cnt & w_mask) == w_mask;
        w_step       = w_tick && !r_paused && !w_ev[1];
        w_cntNext    = r_cnt + 1'b1;
        w_ledNext    = r_led;
        w_dirUpNext  = r_dirUp;
        w_modeNext   = r_mode;
        w_speedNext  = r_speed + SPDW'(w_ev[0]);
        w_pausedNext = r_paused ^ w_ev[2];

        if (w_ev[1]) begin
            w_modeNext  = mode_t'(r_mode + 2'd1);
            w_cntNext   = '0;
            w_dirUpNext = 1'b1;
            case (w_modeNext)
                M_BINARY: w_ledNext = '0;
                M_BLINK:  w_ledNext = '1;
                default:  w_ledNext = LED_ONE;
            endcase
        end else if (w_step) begin
            case (r_mode)
                M_ROTATE: w_ledNext = {r_led[NLED-2:0], r_led[NLED-1]};
                M_PINGPONG: begin
                    if (r_dirUp) begin
                        w_ledNext = r_led << 1;
                        if (r_led[NLED-2]) w_dirUpNext = 1'b0;
                    end else begin
                        w_ledNext = r_led >> 1;
                        if (r_led[1]) w_dirUpNext = 1'b1;
                    end
                end
                M_BINARY: w_ledNext = r_led + LED_ONE;
                default:  w_ledNext = ~r_led;
            endcase
        end
    end

    assign bus.LED    = r_led;
    assign bus.SPEED  = r_speed;
    assign bus.MODE   = r_mode;
    assign bus.PAUSED = r_paused;
endmodule

// File: tb/tb_blinkseq.sv
// Directed bench for blinkseq with a 64-cycle prescaler and a 4-cycle debounce window.
// All expected values are worked out by hand from cycle positions relative to reset release.
module tb_blinkseq;
    logic CLK = 1'b0;
    logic RST;
    int   passCount  = 0;
    int   totalCount = 0;
    int   badCycles;
    logic [3:0] ppSeq [0:6];

    always #5 CLK = ~CLK;

    blinkseq_if #(.NLED(4), .SPDW(2)) bus ();

    blinkseq #(.NLED(4), .DIVW(6), .SPDW(2), .DEBW(2)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // The event lands on the 7th edge after the press starts. The task returns 12 edges after it starts.
    task automatic applyStimulus(input int b);
        bus.BTN[b] = 1'b1;
        step(6);
        bus.BTN[b] = 1'b0;
        step(6);
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        totalCount++;
        assert (obs === exp) passCount++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        ppSeq[0] = 4'b0010; ppSeq[1] = 4'b0100; ppSeq[2] = 4'b1000; ppSeq[3] = 4'b0100;
        ppSeq[4] = 4'b0010; ppSeq[5] = 4'b0001; ppSeq[6] = 4'b0010;
        RST     = 1'b1;
        bus.BTN = 3'b000;
        step(3);
        RST = 1'b0;
        checkOutput("rstLed",    16'(bus.LED),    16'h1);
        checkOutput("rstSpeed",  16'(bus.SPEED),  16'h0);
        checkOutput("rstMode",   16'(bus.MODE),   16'h0);
        checkOutput("rstPaused", 16'(bus.PAUSED), 16'h0);

        step(63); checkOutput("rotHold",  16'(bus.LED), 16'b0001);
        step(1);  checkOutput("rot1",     16'(bus.LED), 16'b0010);
        step(63); checkOutput("rot1Hold", 16'(bus.LED), 16'b0010);
        step(1);  checkOutput("rot2",     16'(bus.LED), 16'b0100);
        step(64); checkOutput("rot3",     16'(bus.LED), 16'b1000);
        step(64); checkOutput("rotWrap",  16'(bus.LED), 16'b0001);

        applyStimulus(0); checkOutput("speed1", 16'(bus.SPEED), 16'd1);
        applyStimulus(0); checkOutput("speed2", 16'(bus.SPEED), 16'd2);
        applyStimulus(0); checkOutput("speed3", 16'(bus.SPEED), 16'd3);
        checkOutput("fastFirst", 16'(bus.LED), 16'b0010);
        step(3); checkOutput("fastHold",  16'(bus.LED), 16'b0010);
        step(1); checkOutput("fastStep",  16'(bus.LED), 16'b0100);
        step(7); checkOutput("fastHold2", 16'(bus.LED), 16'b0100);
        step(1); checkOutput("fastStep2", 16'(bus.LED), 16'b1000);
        applyStimulus(0); checkOutput("speedWrap", 16'(bus.SPEED), 16'd0);
        checkOutput("slowHold", 16'(bus.LED), 16'b1000);
        step(4); checkOutput("slowStep", 16'(bus.LED), 16'b0001);

        applyStimulus(1);
        checkOutput("mode1",     16'(bus.MODE), 16'd1);
        checkOutput("mode1Init", 16'(bus.LED),  16'b0001);
        step(58); checkOutput("ppHold", 16'(bus.LED), 16'b0001);
        for (int i = 0; i < 7; i++) begin
            step(1);
            checkOutput($sformatf("pp%0d", i), 16'(bus.LED), 16'(ppSeq[i]));
            step(63);
        end

        applyStimulus(1);
        checkOutput("mode2",     16'(bus.MODE), 16'd2);
        checkOutput("mode2Init", 16'(bus.LED),  16'b0000);
        step(323); checkOutput("bin5", 16'(bus.LED), 16'b0101);
        applyStimulus(2);
        checkOutput("paused", 16'(bus.PAUSED), 16'd1);
        badCycles = 0;
        for (int i = 0; i < 500; i++) begin
            step(1);
            if (bus.LED !== 4'b0101) badCycles++;
        end
        checkOutput("pauseHold", 16'(badCycles), 16'd0);
        applyStimulus(2);
        checkOutput("resumed",    16'(bus.PAUSED), 16'd0);
        checkOutput("resumeHold", 16'(bus.LED),    16'b0101);
        step(43); checkOutput("resumeHold2", 16'(bus.LED), 16'b0101);
        step(1);  checkOutput("resumeStep",  16'(bus.LED), 16'b0110);

        step(57); checkOutput("binBeforeTie", 16'(bus.LED), 16'b0110);
        applyStimulus(1);
        checkOutput("tieMode", 16'(bus.MODE), 16'd3);
        checkOutput("tieLed",  16'(bus.LED),  16'b1111);

        applyStimulus(0);
        applyStimulus(0);
        applyStimulus(2);
        checkOutput("preRstSpeed",  16'(bus.SPEED),  16'd2);
        checkOutput("preRstMode",   16'(bus.MODE),   16'd3);
        checkOutput("preRstPaused", 16'(bus.PAUSED), 16'd1);
        bus.BTN[1] = 1'b1;
        step(3);
        RST = 1'b1;
        step(1);
        checkOutput("rst2Led",    16'(bus.LED),    16'h1);
        checkOutput("rst2Speed",  16'(bus.SPEED),  16'h0);
        checkOutput("rst2Mode",   16'(bus.MODE),   16'h0);
        checkOutput("rst2Paused", 16'(bus.PAUSED), 16'h0);
        bus.BTN = 3'b000;
        step(4);
        RST = 1'b0;
        step(63);
        checkOutput("rst2Hold",     16'(bus.LED),  16'b0001);
        checkOutput("rst2NoModeEv", 16'(bus.MODE), 16'd0);
        step(1);  checkOutput("rst2Step", 16'(bus.LED), 16'b0010);

        bus.BTN[0] = 1'b1;
        step(40);
        bus.BTN[0] = 1'b0;
        step(8);
        checkOutput("heldOnce", 16'(bus.SPEED), 16'd1);

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end
endmodule
